// File: rtl/mul_pkg.sv
// Shared types and widths for the radix-4 Booth approximate multiplier.
// Latency: none (package only).
// Backpressure: none (package only).
package mul_pkg;

  localparam int IN_W = 8;
  localparam int PP_W = 10;
  localparam int P_W  = 16;

  // Radix-4 Booth digit values
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_dig_e;

  // Map a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]} to its digit
  function automatic booth_dig_e booth_decode(input logic [2:0] win);
    booth_dig_e dig;
    unique case (win)
      3'b000, 3'b111: dig = ZERO;
      3'b001, 3'b010: dig = POS1;
      3'b011:         dig = POS2;
      3'b100:         dig = NEG2;
      default:        dig = NEG1;  // 101, 110
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: digit(window) * a, exact in 10 bits.
// Latency: purely combinational.
// Backpressure: none.
module booth_pp_gen
  import mul_pkg::*;
(
  input  logic [IN_W-1:0] i_a,
  input  logic [2:0]      i_win,
  output logic [PP_W-1:0] o_pp
);

  logic [PP_W-1:0] w_a_ext;
  booth_dig_e      w_dig;

  assign w_a_ext = {{(PP_W-IN_W){i_a[IN_W-1]}}, i_a};
  assign w_dig   = booth_decode(i_win);

  // Select 0, +-a or +-2a; 10 bits hold -256..+256 so negating -2*(-128) is safe
  always_comb begin
    o_pp = '0;
    unique case (w_dig)
      ZERO:    o_pp = '0;
      POS1:    o_pp = w_a_ext;
      POS2:    o_pp = w_a_ext << 1;
      NEG1:    o_pp = -w_a_ext;
      NEG2:    o_pp = -(w_a_ext << 1);
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/carry_aware_booth_mul8.sv
// Registered 8x8 signed Booth multiplier; low APPROX_COLS sum bits ORed, carry out of them exact.
// Latency: 1 cycle from in_valid to out_valid; results hold while in_valid is low.
// Backpressure: none, accepts one operand pair every cycle. Define EXACT_LSB_EN for exact low bits.
module carry_aware_booth_mul8
  import mul_pkg::*;
#(
  parameter int APPROX_COLS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic            out_valid,
  output logic [PP_W-1:0] ps1,
  output logic [PP_W-1:0] ps2,
  output logic [PP_W-1:0] ps3,
  output logic [PP_W-1:0] ps4,
  output logic [P_W-1:0]  p
);

  // Columns below APPROX_COLS form the low (approximated) region
  localparam logic [P_W-1:0] LO_MASK = P_W'((1 << APPROX_COLS) - 1);

  logic [IN_W:0]   w_b_ext;
  logic [PP_W-1:0] w_pp [4];
  logic [P_W-1:0]  w_e  [4];
  logic [P_W+1:0]  w_lo_sum;
  logic [P_W-1:0]  w_lo_or;
  logic [P_W-1:0]  w_hi_sum;
  logic [P_W-1:0]  w_lo_bits;
  logic [P_W-1:0]  w_p;

  // Implicit b[-1] = 0 below the LSB
  assign w_b_ext = {b, 1'b0};

  for (genvar i = 0; i < 4; i++) begin : g_pp
    booth_pp_gen u_pp (
      .i_a   (a),
      .i_win (w_b_ext[2*i+2 -: 3]),
      .o_pp  (w_pp[i])
    );
    // Sign-extend and align each partial product to weight 4^i (mod 2^16)
    assign w_e[i] = {{(P_W-PP_W){w_pp[i][PP_W-1]}}, w_pp[i]} << (2*i);
  end

  // Compress: exact low-region sum for the carry, OR (or true sum) for the low bits
  always_comb begin
    w_lo_sum = '0;
    w_lo_or  = '0;
    w_hi_sum = '0;
    for (int i = 0; i < 4; i++) begin
      w_lo_sum = w_lo_sum + {2'b00, w_e[i] & LO_MASK};
      w_lo_or  = w_lo_or | (w_e[i] & LO_MASK);
      w_hi_sum = w_hi_sum + (w_e[i] & ~LO_MASK);
    end
`ifdef EXACT_LSB_EN
    w_lo_bits = w_lo_sum[P_W-1:0] & LO_MASK;
`else
    w_lo_bits = w_lo_or;
`endif
    // Bits of the low sum at/above APPROX_COLS are exactly the carry into the high region
    w_p = (w_hi_sum + (w_lo_sum[P_W-1:0] & ~LO_MASK)) | w_lo_bits;
  end

  // Output registers: reset clears everything, otherwise capture on in_valid and hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ps1       <= '0;
      ps2       <= '0;
      ps3       <= '0;
      ps4       <= '0;
      p         <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ps1 <= w_pp[0];
        ps2 <= w_pp[1];
        ps3 <= w_pp[2];
        ps4 <= w_pp[3];
        p   <= w_p;
      end
    end
  end

endmodule

// File: tb/tb_carry_aware_booth_mul8.sv
// Scoreboard bench for carry_aware_booth_mul8: stimulus pushes expectations, monitor pops on out_valid.
// Latency: expects results one cycle after each accepted operand pair.
// Backpressure: none; holds are checked while out_valid is low.
module tb_carry_aware_booth_mul8;

  localparam int AC = 4;

  typedef struct {
    logic [15:0] p;
    logic [9:0]  ps1;
    logic [9:0]  ps2;
    logic [9:0]  ps3;
    logic [9:0]  ps4;
    int          sa;
    int          sb;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic [9:0]  ps1, ps2, ps3, ps4;
  logic [15:0] p;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_rst = 1'b0;
  logic prev_vld = 1'b0;

  carry_aware_booth_mul8 #(.APPROX_COLS(AC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .ps1       (ps1),
    .ps2       (ps2),
    .ps3       (ps3),
    .ps4       (ps4),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record what the DUT saw at each rising edge (inputs change 1 time unit later)
  always @(posedge clk) begin
    prev_rst = rst_n;
    prev_vld = in_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: Booth digit as arithmetic -2*b[2i+1] + b[2i] + b[2i-1], then the column rules
  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib);
    exp_t e;
    int bits[9];
    int lm, hm, slo, lor, hsum, low, d, pp, ev, pi;
    lm = (1 << AC) - 1;
    hm = (1 << (16 - AC)) - 1;
    bits[0] = 0;
    for (int k = 0; k < 8; k++) bits[k+1] = int'(ib[k]);
    e.sa = int'($signed(ia));
    e.sb = int'($signed(ib));
    slo = 0; lor = 0; hsum = 0;
    for (int i = 0; i < 4; i++) begin
      d  = -2 * bits[2*i+2] + bits[2*i+1] + bits[2*i];
      pp = d * e.sa;
      case (i)
        0: e.ps1 = 10'(pp);
        1: e.ps2 = 10'(pp);
        2: e.ps3 = 10'(pp);
        default: e.ps4 = 10'(pp);
      endcase
      ev   = (pp * (1 << (2*i))) & 32'hFFFF;
      slo  = slo + (ev & lm);
      lor  = lor | (ev & lm);
      hsum = hsum + (ev >> AC);
    end
`ifdef EXACT_LSB_EN
    low = slo & lm;
`else
    low = lor;
`endif
    pi  = (((hsum + (slo >> AC)) & hm) << AC) | low;
    e.p = 16'(pi);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [7:0] ia, input logic [7:0] ib);
    @(posedge clk);
    #1;
    in_valid = v;
    a        = ia;
    b        = ib;
  endtask

  task automatic issue_model(input logic [7:0] ia, input logic [7:0] ib);
    drive(1'b1, ia, ib);
    q.push_back(model(ia, ib));
  endtask

  task automatic issue_const(input int ia, input int ib, input int ep, input int e1,
                             input int e2, input int e3, input int e4);
    exp_t e;
    drive(1'b1, 8'(ia), 8'(ib));
    e.p = 16'(ep); e.ps1 = 10'(e1); e.ps2 = 10'(e2); e.ps3 = 10'(e3); e.ps4 = 10'(e4);
    e.sa = ia; e.sb = ib;
    q.push_back(e);
  endtask

  // Monitor: on out_valid pop and compare; otherwise check reset zeros or held values
  initial begin : monitor
    exp_t e;
    exp_t held;
    int   diff;
    held.p = '0; held.ps1 = '0; held.ps2 = '0; held.ps3 = '0; held.ps4 = '0;
    forever begin
      @(negedge clk);
      if (!prev_rst) begin
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_p", 32'(p), 32'd0);
        chk("reset_ps", 32'({ps1, ps2, ps3}), 32'd0);
        chk("reset_ps4", 32'(ps4), 32'd0);
        held.p = '0; held.ps1 = '0; held.ps2 = '0; held.ps3 = '0; held.ps4 = '0;
      end else begin
        chk("out_valid", 32'(out_valid), 32'(prev_vld));
        if (out_valid) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got out_valid=1 expected no pending result");
          end else begin
            e = q.pop_front();
            chk("p", 32'(p), 32'(e.p));
            chk("ps1", 32'(ps1), 32'(e.ps1));
            chk("ps2", 32'(ps2), 32'(e.ps2));
            chk("ps3", 32'(ps3), 32'(e.ps3));
            chk("ps4", 32'(ps4), 32'(e.ps4));
            diff = int'($signed(p)) - e.sa * e.sb;
            if (diff < 0) diff = -diff;
`ifdef EXACT_LSB_EN
            chk("exact_err", 32'(diff), 32'd0);
`else
            total++;
            if (diff > (1 << AC) - 1) begin
              bad++;
              $display("FAIL err_bound: got |p-a*b|=%0d expected <= %0d", diff, (1 << AC) - 1);
            end
`endif
            held = e;
          end
        end else begin
          chk("hold_p", 32'(p), 32'(held.p));
          chk("hold_ps", 32'({ps1, ps2, ps3}), 32'({held.ps1, held.ps2, held.ps3}));
          chk("hold_ps4", 32'(ps4), 32'(held.ps4));
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    int waited;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'd5;
    b        = 8'd7;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    drive(1'b0, 8'd0, 8'd0);

    // Directed: single nonzero partial product, carry-aware approximation, extremes
    issue_const(1, 1, 1, 1, 0, 0, 0);
    issue_const(-1, 1, -1, -1, 0, 0, 0);
    issue_const(5, 4, 20, 0, 5, 0, 0);
`ifdef EXACT_LSB_EN
    issue_const(1, 3, 3, -1, 1, 0, 0);
    issue_const(63, 5, 315, 63, 63, 0, 0);
`else
    issue_const(1, 3, 15, -1, 1, 0, 0);
    issue_const(63, 5, 319, 63, 63, 0, 0);
`endif
    issue_const(-128, -128, 16384, 0, 0, 0, 256);
    issue_const(127, -128, -16256, 0, 0, 0, -254);
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b0, 8'hAA, 8'h55);

    // Three back-to-back then idle: results lag by one cycle, then hold
    for (int i = 0; i < 3; i++) issue_model(8'($urandom), 8'($urandom));
    repeat (3) drive(1'b0, 8'($urandom), 8'($urandom));

    // Exhaustive sweep over all operand pairs
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 256; y++)
        issue_model(8'(x), 8'(y));

    // Random pairs with random gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 8'($urandom), 8'($urandom));
      else issue_model(8'($urandom), 8'($urandom));
    end
    drive(1'b0, 8'd0, 8'd0);

    // Drain, bounded
    waited = 0;
    while (q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results expected 0", q.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
